beam_scaler_bank: RTL
=====================

// Module: beam_scaler_bank
// PURPOSE
// Parametrised successor to the quad-DSP beam scaler: counts per-beam trigger pulses
// (real + subthreshold groups) over timer-defined periods in fabric counters, snapshots
// at each period boundary and copies results into a double-banked readout RAM.
// Adds saturation, missed-period flagging and cumulative mode. Sits between trigger
// beamformer outputs (already resynchronised to wb_clk_i) and the wishbone scaler space.
// PARAMETERS
// NBEAMS     48  beams per group (1..64)
// NGROUPS    2   groups: 0 = real, 1 = subthreshold (1..2)
// CNT_WIDTH  12  counter width, 1..24
// ADDR_WIDTH 8   read address width; top bit selects group, low ADDR_WIDTH-1 bits select beam
// PORTS
// wb_clk_i      in   1                    sole clock
// wb_rst_i      in   1                    asynchronous reset, active high
// count_ce_i    in   1                    sample strobe; count_i only sampled when high
// count_i       in   NBEAMS*NGROUPS       pulse per beam; group g beam b at bit g*NBEAMS+b
// timer_i       in   1                    single-cycle period-end pulse
// cumulative_i  in   1                    1 = never clear live counters on snapshot
// done_o        out  1                    1-cycle pulse when a new bank becomes readable
// missed_o      out  1                    sticky: a timer_i was dropped; cleared by clr_missed_i
// clr_missed_i  in   1                    clears missed_o
// scal_rd_i     in   1                    read enable
// scal_adr_i    in   ADDR_WIDTH           read address
// scal_dat_o    out  32                   read data, valid 2 cycles after scal_rd_i
// write_bank_o  out  1                    bank currently being written; reads use the other
// BEHAVIOUR
// Reset (async): all live/shadow counters 0, FSM IDLE, write_bank_o=0, done_o=0, missed_o=0,
//  pending=0, scal_dat_o=0. RAM contents not reset; both banks read as 0 until first swap
//  (per-bank valid bit, cleared on reset).
// Counting: live[c] += count_i[c] when count_ce_i; at all-ones holds and sets sat[c].
// FSM IDLE -> SNAP -> COPY -> SWAP -> IDLE:
//  IDLE: on timer_i or pending -> SNAP; clears pending.
//  SNAP (1 cyc): shadow[c]<=live[c] (incl. this cycle's increment), shadow_sat[c]<=sat[c];
//   live[c] and sat[c] cleared unless cumulative_i (then sat stays set). Increment on the
//   cycle after SNAP belongs to the next period.
//  COPY: NBEAMS*NGROUPS cycles, index g,b from 0,0 ascending; writes word to RAM bank
//   write_bank_o at {g, b}.
//  SWAP (1 cyc): write_bank_o toggles, bank valid set, done_o=1 on the following cycle.
// Timer during SNAP/COPY/SWAP: set pending (1 deep); timer while pending already set ->
//  missed_o=1 and next stored words carry missed bit. timer_i in IDLE same cycle as
//  exit is consumed directly. clr_missed_i and a new miss same cycle: miss wins.
// Data word: [31]=saturated, [30]=period-miss occurred since last copy, [29:24]=0,
//  [23:0]=count zero-extended.
// Read: addr beam >= NBEAMS, group >= NGROUPS, or bank invalid -> 0. Latency 2 cycles,
//  registered output; scal_dat_o holds last value when scal_rd_i low. A swap between
//  scal_rd_i and data valid still returns the old bank (bank sampled with address).
// Reset mid-COPY: aborts, bank not toggled, no done_o.
// Min period: NBEAMS*NGROUPS+3 cycles between timer_i pulses without pending.
// STRUCTURE
// Package beam_scaler_pkg: state enum (IDLE,SNAP,COPY,SWAP), data-word field localparams
//  (SAT_BIT=31, MISS_BIT=30, CNT_MSB=23), function addr_map(g,b).
// Sub-module scaler_bank_ram: simple dual-port RAM, 2*2^ADDR_WIDTH x 32, 1-cycle write,
//  2-cycle registered read, inferred BRAM/LUTRAM.
// TESTING
// NBEAMS=4,NGROUPS=2: 10 strobes on beam 1, 3 on sub beam 2, timer -> done_o after 12 cyc;
//  read 0x01=10, 0x82=3, 0x00=0, write_bank_o=1.
// CNT_WIDTH=4: 20 pulses beam 0 -> read 0x8000000F; next period 2 pulses -> 0x00000002.
// cumulative_i=1: 5 pulses, timer, 5 pulses, timer -> reads 5 then 10.
// Timers at cycle 0,2,4 (copy in progress) -> missed_o=1, second copy word bit30=1;
//  clr_missed_i -> 0.
// Pulse with count_ce_i on SNAP cycle counted in current period; on SNAP+1 in next.
// Assert wb_rst_i mid-COPY -> write_bank_o=0, done_o never pulses, reads return 0.

Source files
------------

// File: rtl/beam_scaler_pkg.sv
// Shared definitions for the beam scaler bank.
//   state_e   : control FSM states (IDLE, SNAP, COPY, SWAP)
//   SAT_BIT   : readout word bit flagging a saturated counter
//   MISS_BIT  : readout word bit flagging a dropped period since the last copy
//   CNT_MSB   : top bit of the zero-extended count field
//   addr_map  : maps (group, beam) onto the readout address space
package beam_scaler_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SNAP = 2'd1,
    COPY = 2'd2,
    SWAP = 2'd3
  } state_e;

  localparam int WORD_W   = 32;
  localparam int SAT_BIT  = 31;
  localparam int MISS_BIT = 30;
  localparam int CNT_MSB  = 23;

  // Group lands on address bit aw-1, beam fills the bits below it.
  function automatic logic [15:0] addr_map(input logic g, input logic [6:0] b,
                                           input int unsigned aw);
    logic [15:0] a;
    a = {9'd0, b} | (16'(g) << (aw - 1));
    return a;
  endfunction

endpackage

// File: rtl/scaler_bank_ram.sv
// Simple dual-port readout RAM holding both banks.
//   clk_i    : clock
//   rst_i    : async reset, clears the read pipeline and output register only
//   we_i     : write enable, waddr_i/wdata_i written on the same edge
//   re_i     : read enable; raddr_i/rzero_i sampled with it
//   rzero_i  : force the returned word to zero (invalid bank / address)
//   rdata_o  : read data, two edges after re_i; holds when no read completes
module scaler_bank_ram #(
  parameter int AW = 9,
  parameter int DW = 32
) (
  input  logic          clk_i,
  input  logic          rst_i,
  input  logic          we_i,
  input  logic [AW-1:0] waddr_i,
  input  logic [DW-1:0] wdata_i,
  input  logic          re_i,
  input  logic [AW-1:0] raddr_i,
  input  logic          rzero_i,
  output logic [DW-1:0] rdata_o
);

  logic [DW-1:0] mem_q [2**AW];
  logic [DW-1:0] rd_stage_q;
  logic [DW-1:0] rdata_q;
  logic          re_q;
  logic          zero_q;

  // Array and first read stage carry no reset so they map onto block RAM.
  always_ff @(posedge clk_i) begin
    if (we_i) mem_q[waddr_i] <= wdata_i;
    if (re_i) rd_stage_q <= mem_q[raddr_i];
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      re_q    <= 1'b0;
      zero_q  <= 1'b0;
      rdata_q <= '0;
    end else begin
      re_q   <= re_i;
      zero_q <= rzero_i;
      if (re_q) rdata_q <= zero_q ? '0 : rd_stage_q;
    end
  end

  assign rdata_o = rdata_q;

endmodule

// File: rtl/beam_scaler_bank.sv
// Per-beam trigger scaler with double-banked readout.
// Counts count_i pulses per channel over periods ended by timer_i, snapshots
// all channels at the period boundary, copies the snapshot into the write
// bank of a readout RAM and then swaps banks so software always reads a
// complete period.
//   wb_clk_i, wb_rst_i : clock, async active-high reset
//   count_ce_i, count_i: sample strobe and per-channel pulses (bit g*NBEAMS+b)
//   timer_i            : single-cycle period-end pulse
//   cumulative_i       : keep live counters running across snapshots
//   done_o             : one-cycle pulse when a new bank becomes readable
//   missed_o           : sticky dropped-timer flag, cleared by clr_missed_i
//   scal_rd_i/adr_i    : read request; scal_dat_o valid two cycles later
//   write_bank_o       : bank being written; reads use the other one
// Read interface: fixed latency, no back-pressure. A cycle with scal_rd_i
// high is a request; its data appears on scal_dat_o two edges later and is
// held until the next completed request.
module beam_scaler_bank
  import beam_scaler_pkg::*;
#(
  parameter int NBEAMS     = 48,
  parameter int NGROUPS    = 2,
  parameter int CNT_WIDTH  = 12,
  parameter int ADDR_WIDTH = 8
) (
  input  logic                      wb_clk_i,
  input  logic                      wb_rst_i,
  input  logic                      count_ce_i,
  input  logic [NBEAMS*NGROUPS-1:0] count_i,
  input  logic                      timer_i,
  input  logic                      cumulative_i,
  output logic                      done_o,
  output logic                      missed_o,
  input  logic                      clr_missed_i,
  input  logic                      scal_rd_i,
  input  logic [ADDR_WIDTH-1:0]     scal_adr_i,
  output logic [31:0]               scal_dat_o,
  output logic                      write_bank_o
);

  localparam int NCH = NBEAMS * NGROUPS;
  localparam logic [CNT_WIDTH-1:0] CNT_MAX = '1;

  state_e state_q, state_d;
  logic   pend_q, pend_d;
  logic   missed_q, missed_d;
  logic   miss_acc_q, miss_acc_d;
  logic   miss_now;
  logic   word_miss_q;
  logic   wbank_q;
  logic [1:0] bank_vld_q;
  logic   done_q;
  logic [7:0] c_q;
  logic [6:0] b_q;
  logic       g_q;

  logic [CNT_WIDTH-1:0] live_q   [NCH];
  logic [CNT_WIDTH-1:0] shadow_q [NCH];
  logic [CNT_WIDTH-1:0] sum_d    [NCH];
  logic [NCH-1:0]       sat_q, sat_d, shadow_sat_q;

  // Live counters: saturate at all-ones and latch the saturation flag.
  always_comb begin
    for (int c = 0; c < NCH; c++) begin
      sum_d[c] = live_q[c];
      sat_d[c] = sat_q[c];
      if (count_ce_i && count_i[c]) begin
        if (live_q[c] == CNT_MAX) sat_d[c] = 1'b1;
        else                      sum_d[c] = live_q[c] + CNT_WIDTH'(1);
      end
    end
  end

  // The SNAP cycle's own increment is part of the closing period, so the
  // shadow takes sum_d rather than live_q.
  always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
    if (wb_rst_i) begin
      for (int c = 0; c < NCH; c++) begin
        live_q[c]   <= '0;
        shadow_q[c] <= '0;
      end
      sat_q        <= '0;
      shadow_sat_q <= '0;
    end else if (state_q == SNAP) begin
      for (int c = 0; c < NCH; c++) begin
        shadow_q[c] <= sum_d[c];
        live_q[c]   <= cumulative_i ? sum_d[c] : '0;
      end
      shadow_sat_q <= sat_d;
      sat_q        <= cumulative_i ? sat_d : '0;
    end else begin
      for (int c = 0; c < NCH; c++) live_q[c] <= sum_d[c];
      sat_q <= sat_d;
    end
  end

  // Control FSM plus pending/miss bookkeeping.
  always_comb begin
    state_d    = state_q;
    pend_d     = pend_q;
    missed_d   = missed_q;
    miss_acc_d = miss_acc_q;
    miss_now   = 1'b0;
    case (state_q)
      IDLE: if (timer_i || pend_q) begin
        state_d = SNAP;
        pend_d  = 1'b0;
      end
      SNAP: state_d = COPY;
      COPY: if (c_q == 8'(NCH - 1)) state_d = SWAP;
      SWAP: state_d = IDLE;
      default: state_d = IDLE;
    endcase
    // Only one boundary can wait; a second one while waiting is dropped.
    if (timer_i && state_q != IDLE) begin
      if (pend_q) miss_now = 1'b1;
      else        pend_d   = 1'b1;
    end
    if (clr_missed_i) missed_d = 1'b0;
    if (miss_now)     missed_d = 1'b1;
    // A miss is reported in the next snapshot taken; one seen during SNAP
    // goes straight into that snapshot.
    if (state_q == SNAP) miss_acc_d = 1'b0;
    else if (miss_now)   miss_acc_d = 1'b1;
  end

  always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
    if (wb_rst_i) begin
      state_q     <= IDLE;
      pend_q      <= 1'b0;
      missed_q    <= 1'b0;
      miss_acc_q  <= 1'b0;
      word_miss_q <= 1'b0;
      wbank_q     <= 1'b0;
      bank_vld_q  <= 2'b00;
      done_q      <= 1'b0;
      c_q         <= '0;
      b_q         <= '0;
      g_q         <= 1'b0;
    end else begin
      state_q    <= state_d;
      pend_q     <= pend_d;
      missed_q   <= missed_d;
      miss_acc_q <= miss_acc_d;
      done_q     <= (state_q == SWAP);
      if (state_q == SNAP) begin
        word_miss_q <= miss_acc_q | miss_now;
        c_q <= '0;
        b_q <= '0;
        g_q <= 1'b0;
      end else if (state_q == COPY) begin
        c_q <= c_q + 8'd1;
        if (b_q == 7'(NBEAMS - 1)) begin
          b_q <= '0;
          g_q <= ~g_q;
        end else begin
          b_q <= b_q + 7'd1;
        end
      end
      if (state_q == SWAP) begin
        wbank_q             <= ~wbank_q;
        bank_vld_q[wbank_q] <= 1'b1;
      end
    end
  end

  // Select the shadow entry for the word being copied.
  logic [CNT_WIDTH-1:0] cnt_sel;
  logic                 sat_sel;
  logic [31:0]          wr_word;

  always_comb begin
    cnt_sel = '0;
    sat_sel = 1'b0;
    for (int c = 0; c < NCH; c++) begin
      if (c_q == 8'(c)) begin
        cnt_sel = shadow_q[c];
        sat_sel = shadow_sat_q[c];
      end
    end
    wr_word            = '0;
    wr_word[SAT_BIT]   = sat_sel;
    wr_word[MISS_BIT]  = word_miss_q;
    wr_word[CNT_MSB:0] = (CNT_MSB + 1)'(cnt_sel);
  end

  logic [ADDR_WIDTH:0] wr_addr, rd_addr;
  logic                rd_bank;
  logic                rd_zero;

  assign wr_addr = {wbank_q, ADDR_WIDTH'(addr_map(g_q, b_q, ADDR_WIDTH))};
  // Bank is captured together with the address, so a swap landing inside
  // the read latency does not change which bank answers.
  assign rd_bank = ~wbank_q;
  assign rd_addr = {rd_bank, scal_adr_i};
  assign rd_zero = !bank_vld_q[rd_bank]
                || (32'(scal_adr_i[ADDR_WIDTH-2:0]) >= 32'(NBEAMS))
                || ((NGROUPS < 2) && scal_adr_i[ADDR_WIDTH-1]);

  scaler_bank_ram #(
    .AW (ADDR_WIDTH + 1),
    .DW (WORD_W)
  ) u_ram (
    .clk_i   (wb_clk_i),
    .rst_i   (wb_rst_i),
    .we_i    (state_q == COPY),
    .waddr_i (wr_addr),
    .wdata_i (wr_word),
    .re_i    (scal_rd_i),
    .raddr_i (rd_addr),
    .rzero_i (rd_zero),
    .rdata_o (scal_dat_o)
  );

  assign done_o       = done_q;
  assign missed_o     = missed_q;
  assign write_bank_o = wbank_q;

endmodule
